// File: rtl/uart_loopback_tester.sv
// uart_loopback_tester: 8N1 byte generator with echo receiver and checker, one byte in flight.
// Define LB_PRBS_EN to advance the pattern as an x^8+x^6+x^5+x^4+1 LFSR instead of incrementing.
module uart_loopback_tester #(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200,
  parameter int NUM_BYTES = 256,
  parameter logic [7:0] SEED = 8'h00,
  parameter int TIMEOUT_BAUDS = 30
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt
);
  localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
  localparam int CW = $clog2(BAUD_CNT + 1);
  localparam int TO_CYC = TIMEOUT_BAUDS * BAUD_CNT;
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [CW-1:0] B_LAST = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] B_HALF = CW'(BAUD_CNT / 2);
  typedef enum logic [2:0] {IDLE, SEND, WAIT, CHECK, NEXT} state_t;
  state_t r_state;
  logic r_s1, r_s2, r_s3;
  logic r_rx_act, r_rx_done, r_rx_ferr, r_rx_vld;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0] r_rx_bit;
  logic [7:0] r_rx_sh, r_rx_data;
  logic r_tx_act;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0] r_tx_bit;
  logic [8:0] r_tx_sh;
  logic [7:0] r_pat;
  logic [15:0] r_idx;
  logic [TW-1:0] r_tcnt;
  logic [7:0] w_pat_nxt;
  logic [15:0] w_err_inc;
  logic w_rx_keep;
`ifdef LB_PRBS_EN
  assign w_pat_nxt = {r_pat[6:0], r_pat[7] ^ r_pat[5] ^ r_pat[4] ^ r_pat[3]};
`else
  assign w_pat_nxt = r_pat + 8'd1;
`endif
  assign w_err_inc = (&err_cnt) ? err_cnt : err_cnt + 16'd1;
  // The echo of the current byte finishes before our own stop bit ends, so hold it from launch until consumed.
  assign w_rx_keep = (r_state == SEND && r_tx_act) || r_state == WAIT;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      {r_s3, r_s2, r_s1} <= 3'b111;
      r_rx_act <= 1'b0;
      r_rx_done <= 1'b0;
      r_rx_ferr <= 1'b0;
      r_rx_cnt <= '0;
      r_rx_bit <= '0;
      r_rx_sh <= '0;
      r_rx_data <= '0;
    end else begin
      {r_s3, r_s2, r_s1} <= {r_s2, r_s1, uart_rxd};
      r_rx_done <= 1'b0;
      if (!r_rx_act) begin
        if (r_s3 && !r_s2) begin
          r_rx_act <= 1'b1;
          r_rx_cnt <= CW'(1);
          r_rx_bit <= '0;
        end
      end else begin
        r_rx_cnt <= (r_rx_cnt == B_LAST) ? '0 : r_rx_cnt + CW'(1);
        if (r_rx_cnt == B_LAST) r_rx_bit <= r_rx_bit + 4'd1;
        if (r_rx_cnt == B_HALF) begin
          if (r_rx_bit == 4'd0 && r_s2) r_rx_act <= 1'b0;
          else if (r_rx_bit == 4'd9) begin
            r_rx_act <= 1'b0;
            r_rx_done <= 1'b1;
            r_rx_ferr <= ~r_s2;
            r_rx_data <= r_rx_sh;
          end else if (r_rx_bit != 4'd0) r_rx_sh <= {r_s2, r_rx_sh[7:1]};
        end
      end
    end
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= IDLE;
      uart_txd <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_cnt <= '0;
      r_pat <= '0;
      r_idx <= '0;
      r_tcnt <= '0;
      r_tx_act <= 1'b0;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh <= '1;
      r_rx_vld <= 1'b0;
    end else begin
      done <= 1'b0;
      r_rx_vld <= w_rx_keep & (r_rx_vld | r_rx_done);
      case (r_state)
        IDLE: if (start) begin
          busy <= 1'b1;
          err_cnt <= '0;
          pass <= 1'b0;
          r_pat <= SEED;
          r_idx <= '0;
          r_tx_act <= 1'b0;
          r_state <= SEND;
        end
        SEND: if (!r_tx_act) begin
          r_tx_act <= 1'b1;
          uart_txd <= 1'b0;
          r_tx_cnt <= '0;
          r_tx_bit <= '0;
          r_tx_sh <= {1'b1, r_pat};
        end else if (r_tx_cnt != B_LAST) r_tx_cnt <= r_tx_cnt + CW'(1);
        else begin
          r_tx_cnt <= '0;
          r_tx_bit <= r_tx_bit + 4'd1;
          uart_txd <= r_tx_sh[0];
          r_tx_sh <= {1'b1, r_tx_sh[8:1]};
          if (r_tx_bit == 4'd9) begin
            r_tx_act <= 1'b0;
            r_tcnt <= TW'(TO_CYC - 1);
            r_state <= WAIT;
          end
        end
        WAIT: if (r_rx_vld) r_state <= CHECK;
        else if (r_tcnt == '0) begin
          err_cnt <= w_err_inc;
          r_state <= NEXT;
        end else r_tcnt <= r_tcnt - TW'(1);
        CHECK: begin
          if (r_rx_data != r_pat || r_rx_ferr) err_cnt <= w_err_inc;
          r_state <= NEXT;
        end
        NEXT: begin
          r_pat <= w_pat_nxt;
          r_idx <= r_idx + 16'd1;
          if (r_idx == 16'(NUM_BYTES - 1)) begin
            r_state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_cnt == '0);
          end else r_state <= SEND;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
